// File: rtl/dbus_read_mux_pkg.sv
// Shared bus-block definitions: FSM state encoding for the read multiplexer.
package dbus_read_mux_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/dbus_onehot_enc.sv
// Chip-select encoder: index of the lowest set bit, any-set and exactly-one-set flags.
module dbus_onehot_enc #(
  parameter int unsigned NCH = 6,
  localparam int unsigned IW = $clog2(NCH)
) (
  input  logic [NCH-1:0] cs,
  output logic [IW-1:0]  idx,
  output logic           any,
  output logic           one
);

  localparam logic [NCH-1:0] LSB_ONE = {{(NCH-1){1'b0}}, 1'b1};

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cs[i]) idx = IW'(i);
    end
  end

  assign any = |cs;
  assign one = any && ((cs & (cs - LSB_ONE)) == '0);

endmodule

// File: rtl/dbus_read_mux.sv
// Registered read-data mux between the external CPU bus and peripheral channels,
// with wait-state insertion, timeout substitution and sticky fault flags.
module dbus_read_mux
  import dbus_read_mux_pkg::*;
#(
  parameter int unsigned     BW       = 8,
  parameter int unsigned     NCH      = 6,
  parameter int unsigned     TOUT     = 15,
  parameter logic [BW-1:0]   DEF_DATA = 8'hFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH-1:0]    CS,
  input  logic              nRD,
  input  logic [NCH*BW-1:0] DI,
  input  logic [NCH-1:0]    RDY,
  input  logic              ERR_CLR,
  output logic [BW-1:0]     DO,
  output logic              DOE,
  output logic              nWAIT,
  output logic              ERR_MULTI,
  output logic              ERR_TOUT
);

  localparam int unsigned IW = $clog2(NCH);
  localparam int unsigned CW = $clog2(TOUT + 1);

  state_t          state, state_nx;
  logic [IW-1:0]   sel, sel_nx;
  logic [CW-1:0]   count, count_nx;
  logic [BW-1:0]   do_nx;
  logic            set_multi, set_tout;
  logic [IW-1:0]   enc_idx;
  logic            enc_any, enc_one;
  logic [BW-1:0]   ch_data [NCH];

  dbus_onehot_enc #(.NCH(NCH)) u_enc (
    .cs  (CS),
    .idx (enc_idx),
    .any (enc_any),
    .one (enc_one)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_data[g] = DI[g*BW +: BW];
  end

  // Next-state, capture and error-set decode.
  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    count_nx  = count;
    do_nx     = DO;
    set_multi = 1'b0;
    set_tout  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!nRD && enc_any) begin
          if (!enc_one) begin
            set_multi = 1'b1;
            state_nx  = ST_FAULT;
          end else if (RDY[enc_idx]) begin
            do_nx    = ch_data[enc_idx];
            state_nx = ST_HOLD;
          end else begin
            sel_nx   = enc_idx;
            count_nx = '0;
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (nRD || !CS[sel]) begin
          state_nx = ST_IDLE;
        end else if (RDY[sel]) begin
          do_nx    = ch_data[sel];
          state_nx = ST_HOLD;
        end else if (count == CW'(TOUT - 1)) begin
          do_nx    = DEF_DATA;
          set_tout = 1'b1;
          state_nx = ST_HOLD;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      ST_HOLD: begin
        if (nRD || !enc_any) state_nx = ST_IDLE;
      end
      ST_FAULT: begin
        if (nRD) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      sel       <= '0;
      count     <= '0;
      DO        <= DEF_DATA;
      DOE       <= 1'b0;
      nWAIT     <= 1'b1;
      ERR_MULTI <= 1'b0;
      ERR_TOUT  <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      count     <= count_nx;
      DO        <= do_nx;
      DOE       <= (state_nx == ST_HOLD);
      nWAIT     <= (state_nx != ST_WAIT);
      ERR_MULTI <= set_multi | (ERR_MULTI & ~ERR_CLR);
      ERR_TOUT  <= set_tout  | (ERR_TOUT  & ~ERR_CLR);
    end
  end

endmodule
